instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle fetch/decode/execute controller that sits directly upstream of the 16×16 register file. It fetches 16-bit instructions from instruction memory over a request/ready handshake and decodes them. It drives the register file's read_select_1, read_select_2, write_select and write inputs. It also supplies ALU control, immediates and flag-register enables to the datapath, and maintains the PC, including conditional branches and jumps.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- instr_req  out  1  instruction fetch request; address on pc.
- instr_ready  in  1  memory has instr_data valid for current pc.
- instr_data  in  16  instruction word.
- pc  out  16  current program counter.
- read_select_1  out  4  register file port 1 select (operand A / jump target).
- read_select_2  out  4  register file port 2 select (operand B).
- write_select  out  4  register file write select (Rdest).
- write  out  1  register file write enable.
- reg_data_1  in  16  register file output_reg_1 (jump target).
- flags  in  5  {C,L,F,Z,N} from flag register.
- flag_we  out  1  flag register capture enable.
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASSB.
- use_imm  out  1  ALU operand B = imm instead of register port 2.
- imm  out  16  extended immediate.
- halted  out  1  sequencer stopped on HALT.
- illegal  out  1  one-cycle pulse on undecodable instruction.

## Operation
- Instruction fields: op = IR[15:12], rd = IR[11:8], ext = IR[7:4], rs = IR[3:0], imm8 = IR[7:0].
- Register form (op 0000): ext 0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV.
- Immediate form: op uses the same codes as ext, with imm = sign-extended imm8. LUI (op 1111) uses imm = {imm8, 8'h00}.
- Bcond (op 1100): cond = rd, signed displacement imm8.
- Jcond (op 0100, ext 1100): cond = rd, target register rs.
- HALT: op 0100, ext 0000.
- Any other encoding is illegal: treated as NOP, illegal pulses in EXECUTE.
- Selects:
  - read_select_1 = rd, except Jcond uses rs.
  - read_select_2 = rs.
  - write_select = rd.
- ALU op mapping: CMP/CMPI use SUB; MOV/MOVI/LUI use PASSB.
- write = 1 in EXECUTE for every arithmetic/logic/move op, including their immediate forms, except CMP/CMPI.
- flag_we = 1 in EXECUTE for ADD/ADDI/SUB/SUBI/CMP/CMPI.
- Conditions (sub-module branch_cond):
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C.
  - HI 0100 L; LS 0101 !L; GT 0110 N; LE 0111 !N.
  - FS 1000 F; FC 1001 !F; LO 1010 !L&!Z; HS 1011 L|Z.
  - LT 1100 !N&!Z; GE 1101 N|Z; UC 1110 always; 1111 never.
- PC update in EXECUTE, 16-bit wrap-around:
  - Bcond taken: pc + sext(imm8).
  - Jcond taken: reg_data_1.
  - Otherwise: pc + 1.
- States:
  - FETCH: instr_req = 1. On instr_ready, IR <= instr_data and go to DECODE; otherwise stay.
  - DECODE: selects stable; register file read settles. Always go to EXECUTE.
  - EXECUTE: write/flag_we/illegal asserted; PC updated. Go to FETCH, or to HALT on HALT.
  - HALT: all enables 0, halted = 1. Exits only via reset.

## Timing
- Reset values: pc = RESET_PC; IR = 16'h0000, so all selects are 0; instr_req, write, flag_we, use_imm, illegal and halted are 0; imm = 0; alu_op = 000; state = FETCH.
- instr_req rises in the first clock after reset deasserts. instr_req stays high, with pc stable, until instr_ready is sampled high.
- Zero-wait memory gives 3 cycles per instruction. Each wait cycle adds one.
- Selects, alu_op, use_imm and imm are decoded combinationally from IR. They are valid from DECODE through EXECUTE.
- write/flag_we are high only during EXECUTE. The register file and flag register capture at the EXECUTE→FETCH edge.
- The new pc is visible in the following FETCH.
- instr_ready high outside FETCH is ignored.
- A reset assertion in any state, including mid-fetch, abandons the operation. No write may be issued after reset goes low.

## Structure
- Shared package isa_pkg holds:
  - opcode/ext constants;
  - condition codes;
  - alu_op encodings;
  - state enum {FETCH, DECODE, EXECUTE, HALT};
  - flag bit indices.
- One sub-module, branch_cond: combinational cond × flags → taken.
- The FSM, IR, PC and decode logic live in instr_sequencer.

## Test plan
- Reset then fetch: release reset with instr_ready = 0 for 3 cycles → instr_req = 1, pc = 0000 held, write = 0 throughout.
- ADDI r3, -2 (16'h53FE): expect DECODE/EXECUTE with read_select_1 = 3, imm = FFFE, use_imm = 1, alu_op = 000, write = 1, flag_we = 1 for exactly one cycle, write_select = 3, then pc = 0001.
- CMP r1, r2 (16'h01B2): expect alu_op = 001, flag_we = 1, write = 0.
- BEQ -4 at pc = 0010 (16'hC0FC):
  - Z = 1 → next pc = 000C.
  - Z = 0 → next pc = 0011.
  - BNE with Z = 0 at pc = FFFF, disp +1 → pc wraps to 0000.
- JUC r5 (16'h4EC5) with reg_data_1 = 1234: expect read_select_1 = 5, write = 0, next pc = 1234.
- HALT (16'h4000) → halted = 1 and instr_req = 0 permanently. Undefined word 16'h7000 → illegal pulse, no write, pc + 1. Reset asserted during a FETCH wait → outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/isa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : isa_pkg                                                   |
// | Purpose  : Shared ISA encodings, ALU ops, condition codes and states  |
// | Revision : 1.0                                                      |
// +----------------------------------------------------------------------+
package isa_pkg;

  // ALU-class codes: ext field in register form, opcode in immediate form
  localparam logic [3:0] c_code_add = 4'b0101;
  localparam logic [3:0] c_code_sub = 4'b1001;
  localparam logic [3:0] c_code_cmp = 4'b1011;
  localparam logic [3:0] c_code_and = 4'b0001;
  localparam logic [3:0] c_code_or  = 4'b0010;
  localparam logic [3:0] c_code_xor = 4'b0011;
  localparam logic [3:0] c_code_mov = 4'b1101;

  localparam logic [3:0] c_op_reg  = 4'b0000;
  localparam logic [3:0] c_op_jmp  = 4'b0100;
  localparam logic [3:0] c_op_bcc  = 4'b1100;
  localparam logic [3:0] c_op_lui  = 4'b1111;
  localparam logic [3:0] c_ext_jcc  = 4'b1100;
  localparam logic [3:0] c_ext_halt = 4'b0000;

  localparam logic [3:0] c_cond_eq = 4'b0000;
  localparam logic [3:0] c_cond_ne = 4'b0001;
  localparam logic [3:0] c_cond_cs = 4'b0010;
  localparam logic [3:0] c_cond_cc = 4'b0011;
  localparam logic [3:0] c_cond_hi = 4'b0100;
  localparam logic [3:0] c_cond_ls = 4'b0101;
  localparam logic [3:0] c_cond_gt = 4'b0110;
  localparam logic [3:0] c_cond_le = 4'b0111;
  localparam logic [3:0] c_cond_fs = 4'b1000;
  localparam logic [3:0] c_cond_fc = 4'b1001;
  localparam logic [3:0] c_cond_lo = 4'b1010;
  localparam logic [3:0] c_cond_hs = 4'b1011;
  localparam logic [3:0] c_cond_lt = 4'b1100;
  localparam logic [3:0] c_cond_ge = 4'b1101;
  localparam logic [3:0] c_cond_uc = 4'b1110;
  localparam logic [3:0] c_cond_nv = 4'b1111;

  localparam logic [2:0] c_alu_add   = 3'b000;
  localparam logic [2:0] c_alu_sub   = 3'b001;
  localparam logic [2:0] c_alu_and   = 3'b010;
  localparam logic [2:0] c_alu_or    = 3'b011;
  localparam logic [2:0] c_alu_xor   = 3'b100;
  localparam logic [2:0] c_alu_passb = 3'b101;

  // Bit positions within the {C,L,F,Z,N} flag vector
  localparam int c_flag_c = 4;
  localparam int c_flag_l = 3;
  localparam int c_flag_f = 2;
  localparam int c_flag_z = 1;
  localparam int c_flag_n = 0;

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    DECODE  = 2'b01,
    EXECUTE = 2'b10,
    HALT    = 2'b11
  } state_t;

  function automatic logic is_alu_code(input logic [3:0] code);
    return (code == c_code_add) || (code == c_code_sub) || (code == c_code_cmp) ||
           (code == c_code_and) || (code == c_code_or)  || (code == c_code_xor) ||
           (code == c_code_mov);
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [3:0] code);
    logic [2:0] op;
    case (code)
      c_code_sub, c_code_cmp: op = c_alu_sub;
      c_code_and:             op = c_alu_and;
      c_code_or:              op = c_alu_or;
      c_code_xor:             op = c_alu_xor;
      c_code_mov:             op = c_alu_passb;
      default:                op = c_alu_add;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : instr_sequencer_if                                        |
// | Purpose  : Fetch bus plus register-file/datapath control bundle       |
// | Revision : 1.0                                                      |
// +----------------------------------------------------------------------+
interface instr_sequencer_if;
  logic        instr_req;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [15:0] pc;
  logic [3:0]  read_select_1;
  logic [3:0]  read_select_2;
  logic [3:0]  write_select;
  logic        write;
  logic [15:0] reg_data_1;
  logic [4:0]  flags;
  logic        flag_we;
  logic [2:0]  alu_op;
  logic        use_imm;
  logic [15:0] imm;
  logic        halted;
  logic        illegal;

  modport master (
    output instr_req, pc, read_select_1, read_select_2, write_select, write,
           flag_we, alu_op, use_imm, imm, halted, illegal,
    input  instr_ready, instr_data, reg_data_1, flags
  );

  modport slave (
    input  instr_req, pc, read_select_1, read_select_2, write_select, write,
           flag_we, alu_op, use_imm, imm, halted, illegal,
    output instr_ready, instr_data, reg_data_1, flags
  );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer_branch_cond.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : branch_cond                                               |
// | Purpose  : Evaluates a 4-bit condition code against {C,L,F,Z,N}       |
// | Revision : 1.0                                                      |
// +----------------------------------------------------------------------+
module branch_cond
  import isa_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [4:0] i_flags,
  output logic       o_taken
);

  logic w_c, w_l, w_f, w_z, w_n;
  assign w_c = i_flags[c_flag_c];
  assign w_l = i_flags[c_flag_l];
  assign w_f = i_flags[c_flag_f];
  assign w_z = i_flags[c_flag_z];
  assign w_n = i_flags[c_flag_n];

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      c_cond_eq: o_taken = w_z;
      c_cond_ne: o_taken = !w_z;
      c_cond_cs: o_taken = w_c;
      c_cond_cc: o_taken = !w_c;
      c_cond_hi: o_taken = w_l;
      c_cond_ls: o_taken = !w_l;
      c_cond_gt: o_taken = w_n;
      c_cond_le: o_taken = !w_n;
      c_cond_fs: o_taken = w_f;
      c_cond_fc: o_taken = !w_f;
      c_cond_lo: o_taken = !w_l && !w_z;
      c_cond_hs: o_taken = w_l || w_z;
      c_cond_lt: o_taken = !w_n && !w_z;
      c_cond_ge: o_taken = w_n || w_z;
      c_cond_uc: o_taken = 1'b1;
      c_cond_nv: o_taken = 1'b0;
      default:   o_taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : instr_sequencer                                           |
// | Purpose  : Fetch/decode/execute controller driving regfile and ALU    |
// | Revision : 1.0                                                      |
// +----------------------------------------------------------------------+
module instr_sequencer
  import isa_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  instr_sequencer_if.master  bus
);

  state_t      r_state;
  logic [15:0] r_ir;
  logic [15:0] r_pc;
  logic        r_instr_req;
  logic        r_write;
  logic        r_flag_we;
  logic        r_illegal;
  logic        r_halted;

  logic [3:0]  w_op, w_rd, w_ext, w_rs, w_code;
  logic [7:0]  w_imm8;
  logic [15:0] w_sext, w_pc_next;
  logic        w_reg_form, w_imm_form, w_arith, w_lui, w_bcc, w_jcc, w_halt;
  logic        w_legal, w_dec_write, w_dec_flag_we, w_taken;

  assign w_op   = r_ir[15:12];
  assign w_rd   = r_ir[11:8];
  assign w_ext  = r_ir[7:4];
  assign w_rs   = r_ir[3:0];
  assign w_imm8 = r_ir[7:0];
  assign w_sext = {{8{w_imm8[7]}}, w_imm8};

  // Immediate-form opcodes reuse the register-form ext codes; none collide with 0/4/C/F
  assign w_reg_form = (w_op == c_op_reg) && is_alu_code(w_ext);
  assign w_imm_form = (w_op != c_op_reg) && is_alu_code(w_op);
  assign w_arith    = w_reg_form || w_imm_form;
  assign w_code     = w_reg_form ? w_ext : w_op;
  assign w_lui      = (w_op == c_op_lui);
  assign w_bcc      = (w_op == c_op_bcc);
  assign w_jcc      = (w_op == c_op_jmp) && (w_ext == c_ext_jcc);
  assign w_halt     = (w_op == c_op_jmp) && (w_ext == c_ext_halt);
  assign w_legal    = w_arith || w_lui || w_bcc || w_jcc || w_halt;

  assign w_dec_write   = (w_arith && (w_code != c_code_cmp)) || w_lui;
  assign w_dec_flag_we = w_arith && ((w_code == c_code_add) || (w_code == c_code_sub) ||
                                     (w_code == c_code_cmp));

  branch_cond u_branch_cond (
    .i_cond  (w_rd),
    .i_flags (bus.flags),
    .o_taken (w_taken)
  );

  always_comb begin
    w_pc_next = r_pc + 16'd1;
    if (w_bcc && w_taken) begin
      w_pc_next = r_pc + w_sext;
    end else if (w_jcc && w_taken) begin
      w_pc_next = bus.reg_data_1;
    end
  end

  // Enables are registered one state early so they are high exactly during EXECUTE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FETCH;
      r_ir        <= 16'h0000;
      r_pc        <= RESET_PC;
      r_instr_req <= 1'b0;
      r_write     <= 1'b0;
      r_flag_we   <= 1'b0;
      r_illegal   <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_write   <= 1'b0;
      r_flag_we <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        FETCH: begin
          if (r_instr_req && bus.instr_ready) begin
            r_ir        <= bus.instr_data;
            r_instr_req <= 1'b0;
            r_state     <= DECODE;
          end else begin
            r_instr_req <= 1'b1;
          end
        end
        DECODE: begin
          r_write   <= w_dec_write;
          r_flag_we <= w_dec_flag_we;
          r_illegal <= !w_legal;
          r_state   <= EXECUTE;
        end
        EXECUTE: begin
          r_pc <= w_pc_next;
          if (w_halt) begin
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else begin
            r_instr_req <= 1'b1;
            r_state     <= FETCH;
          end
        end
        HALT: begin
          r_halted    <= 1'b1;
          r_instr_req <= 1'b0;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign bus.instr_req     = r_instr_req;
  assign bus.pc            = r_pc;
  assign bus.read_select_1 = w_jcc ? w_rs : w_rd;
  assign bus.read_select_2 = w_rs;
  assign bus.write_select  = w_rd;
  assign bus.write         = r_write;
  assign bus.flag_we       = r_flag_we;
  assign bus.illegal       = r_illegal;
  assign bus.halted        = r_halted;
  assign bus.use_imm       = w_imm_form || w_lui;
  assign bus.imm           = w_lui ? {w_imm8, 8'h00} : w_sext;
  assign bus.alu_op        = w_lui ? c_alu_passb : (w_arith ? alu_op_of(w_code) : c_alu_add);

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_instr_sequencer                                        |
// | Purpose  : Directed program run against an instruction-level model    |
// | Revision : 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if bif ();

  instr_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  logic [15:0] mem  [0:65535];
  logic [15:0] regs [0:15];
  logic [4:0]  flags_v = 5'b00010;
  logic        ready_v = 1'b0;
  int          ready_mode = 0;

  assign bif.instr_ready = ready_v;
  assign bif.instr_data  = ready_v ? mem[bif.pc] : 16'hDEAD;
  assign bif.reg_data_1  = regs[bif.read_select_1];
  assign bif.flags       = flags_v;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  function automatic string alu_name(input logic [3:0] c);
    case (c)
      4'h5: return "ADD";
      4'h9: return "SUB";
      4'hB: return "CMP";
      4'h1: return "AND";
      4'h2: return "OR";
      4'h3: return "XOR";
      4'hD: return "MOV";
      default: return "";
    endcase
  endfunction

  function automatic string mnem(input logic [15:0] ir);
    logic [3:0] op, ext;
    op  = ir[15:12];
    ext = ir[7:4];
    if (op == 4'h0) return (alu_name(ext) == "") ? "ILL" : alu_name(ext);
    if (op == 4'hF) return "LUI";
    if (op == 4'hC) return "B";
    if (op == 4'h4) return (ext == 4'hC) ? "J" : ((ext == 4'h0) ? "HALT" : "ILL");
    return (alu_name(op) == "") ? "ILL" : {alu_name(op), "I"};
  endfunction

  function automatic logic [2:0] exp_alu(input string m);
    case (m)
      "SUB", "SUBI", "CMP", "CMPI": return 3'd1;
      "AND", "ANDI":                return 3'd2;
      "OR", "ORI":                  return 3'd3;
      "XOR", "XORI":                return 3'd4;
      "MOV", "MOVI", "LUI":         return 3'd5;
      default:                      return 3'd0;
    endcase
  endfunction

  function automatic logic exp_write(input string m);
    case (m)
      "ADD", "ADDI", "SUB", "SUBI", "AND", "ANDI", "OR", "ORI",
      "XOR", "XORI", "MOV", "MOVI", "LUI": return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic exp_fwe(input string m);
    case (m)
      "ADD", "ADDI", "SUB", "SUBI", "CMP", "CMPI": return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic exp_uimm(input string m);
    case (m)
      "ADDI", "SUBI", "CMPI", "ANDI", "ORI", "XORI", "MOVI", "LUI": return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int disp(input logic [7:0] b);
    return b[7] ? int'(b) - 256 : int'(b);
  endfunction

  function automatic logic [15:0] exp_imm(input logic [15:0] ir);
    if (mnem(ir) == "LUI") return ir[7:0] * 16'd256;
    return 16'(disp(ir[7:0]));
  endfunction

  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
    logic fc, fl, ff, fz, fn;
    {fc, fl, ff, fz, fn} = f;
    case (c)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fl;
      4'd5:  return !fl;
      4'd6:  return fn;
      4'd7:  return !fn;
      4'd8:  return ff;
      4'd9:  return !ff;
      4'd10: return !fl && !fz;
      4'd11: return fl || fz;
      4'd12: return !fn && !fz;
      4'd13: return fn || fz;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] next_pc(input logic [15:0] pc, input logic [15:0] ir,
                                          input logic [4:0] f);
    string m;
    m = mnem(ir);
    if (m == "B" && cond_true(ir[11:8], f)) return 16'(int'(pc) + disp(ir[7:0]));
    if (m == "J" && cond_true(ir[11:8], f)) return regs[ir[3:0]];
    return 16'(int'(pc) + 1);
  endfunction

  task automatic chk_dec(input string tag, input logic [15:0] ir);
    string m;
    m = mnem(ir);
    chk({tag, "_rs1"}, bif.read_select_1, (m == "J") ? ir[3:0] : ir[11:8]);
    chk({tag, "_rs2"}, bif.read_select_2, ir[3:0]);
    chk({tag, "_ws"},  bif.write_select, ir[11:8]);
    chk({tag, "_alu"}, bif.alu_op, exp_alu(m));
    chk({tag, "_uimm"}, bif.use_imm, exp_uimm(m));
    chk({tag, "_imm"}, bif.imm, exp_imm(ir));
  endtask

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] imm;
    logic [3:0]  rs1;
    logic [3:0]  ws;
    logic        wr;
    logic        fwe;
    logic        ill;
    logic        uimm;
    logic [2:0]  alu;
  } rec_t;
  rec_t log_q[$];

  int          m_phase = 0;   // 0 fetch, 1 decode, 2 execute, 3 halted
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_ir = 16'h0000;
  bit          m_fresh = 1'b1;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      m_phase = 0;
      m_pc    = 16'h0000;
      m_ir    = 16'h0000;
      m_fresh = 1'b1;
      chk("rst_req", bif.instr_req, 0);
      chk("rst_pc", bif.pc, 16'h0000);
      chk("rst_write", bif.write, 0);
      chk("rst_fwe", bif.flag_we, 0);
      chk("rst_ill", bif.illegal, 0);
      chk("rst_halted", bif.halted, 0);
      chk("rst_sel", {bif.read_select_1, bif.read_select_2, bif.write_select}, 0);
      chk("rst_imm", bif.imm, 0);
      chk("rst_alu", bif.alu_op, 0);
      chk("rst_uimm", bif.use_imm, 0);
    end else begin
      case (m_phase)
        0: begin
          chk("f_req", bif.instr_req, m_fresh ? 0 : 1);
          chk("f_pc", bif.pc, m_pc);
          chk("f_en", {bif.write, bif.flag_we, bif.illegal, bif.halted}, 0);
          if (!m_fresh && ready_v) begin
            m_ir    = mem[m_pc];
            m_phase = 1;
          end
        end
        1: begin
          chk("d_req", bif.instr_req, 0);
          chk("d_en", {bif.write, bif.flag_we, bif.illegal, bif.halted}, 0);
          chk_dec("d", m_ir);
          m_phase = 2;
        end
        2: begin
          rec_t r;
          chk("e_req", bif.instr_req, 0);
          chk("e_pc", bif.pc, m_pc);
          chk("e_write", bif.write, exp_write(mnem(m_ir)));
          chk("e_fwe", bif.flag_we, exp_fwe(mnem(m_ir)));
          chk("e_ill", bif.illegal, mnem(m_ir) == "ILL");
          chk("e_halted", bif.halted, 0);
          chk_dec("e", m_ir);
          r.pc = bif.pc;  r.ir = m_ir;  r.imm = bif.imm;  r.rs1 = bif.read_select_1;
          r.ws = bif.write_select;  r.wr = bif.write;  r.fwe = bif.flag_we;
          r.ill = bif.illegal;  r.uimm = bif.use_imm;  r.alu = bif.alu_op;
          log_q.push_back(r);
          m_phase = (mnem(m_ir) == "HALT") ? 3 : 0;
          m_pc    = next_pc(m_pc, m_ir, flags_v);
        end
        default: begin
          chk("h_halted", bif.halted, 1);
          chk("h_req", bif.instr_req, 0);
          chk("h_en", {bif.write, bif.flag_we, bif.illegal}, 0);
          chk("h_pc", bif.pc, m_pc);
        end
      endcase
      m_fresh = 1'b0;
    end
  end

  // Memory responder: ready pattern chosen by ready_mode, also toggles outside FETCH
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       ready_v = 1'b0;
      1:       ready_v = ($urandom_range(0, 2) != 0);
      default: ready_v = 1'b1;
    endcase
  end

  task automatic wait_pc(input logic [15:0] target, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (bif.instr_req && bif.pc == target) hit = 1'b1;
    end
    chk($sformatf("reach_pc_%h", target), hit, 1);
  endtask

  initial begin
    bit got_halt;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h7000;
    for (int i = 0; i < 16; i++) regs[i] = 16'(i * 16'h0101);
    regs[5] = 16'h1234;
    regs[6] = 16'h0010;
    regs[7] = 16'hFFFF;
    regs[8] = 16'h0010;
    mem[16'h0000] = 16'h53FE;  // ADDI r3,-2
    mem[16'h0001] = 16'h01B2;  // CMP r1,r2
    mem[16'h0002] = 16'h7000;  // undefined
    mem[16'h0003] = 16'h4EC5;  // JUC r5
    mem[16'h1234] = 16'h4EC8;  // JUC r8
    mem[16'h0010] = 16'hC0FC;  // BEQ -4
    mem[16'h000C] = 16'h1A0F;  // ANDI r10,0x0F
    mem[16'h000D] = 16'h2B80;  // ORI r11,-128
    mem[16'h000E] = 16'hF4AB;  // LUI r4,0xAB
    mem[16'h000F] = 16'h4EC6;  // JUC r6
    mem[16'h0011] = 16'h4EC7;  // JUC r7
    mem[16'hFFFF] = 16'hC101;  // BNE +1

    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_pc", bif.pc, 16'h0000);
    chk("lit_rst_req", bif.instr_req, 0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("lit_wait_req", bif.instr_req, 1);
    chk("lit_wait_pc", bif.pc, 16'h0000);
    ready_mode = 1;

    wait_pc(16'h000F, 400);
    @(posedge clk);
    #1;
    flags_v = 5'b00000;
    wait_pc(16'h0011, 400);
    mem[16'h0000] = 16'h4000;  // HALT on wrap-around

    got_halt = 1'b0;
    for (int i = 0; i < 400 && !got_halt; i++) begin
      @(negedge clk);
      if (bif.halted) got_halt = 1'b1;
    end
    chk("reach_halt", got_halt, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("lit_halt_req", bif.instr_req, 0);
    chk("lit_halted", bif.halted, 1);

    chk("log_len", log_q.size() >= 14, 1);
    if (log_q.size() >= 14) begin
      chk("addi_pc", log_q[0].pc, 16'h0000);
      chk("addi_rs1", log_q[0].rs1, 4'd3);
      chk("addi_ws", log_q[0].ws, 4'd3);
      chk("addi_imm", log_q[0].imm, 16'hFFFE);
      chk("addi_ctl", {log_q[0].uimm, log_q[0].alu, log_q[0].wr, log_q[0].fwe}, 6'b1_000_11);
      chk("cmp_pc", log_q[1].pc, 16'h0001);
      chk("cmp_ctl", {log_q[1].alu, log_q[1].wr, log_q[1].fwe}, 5'b001_01);
      chk("ill_ctl", {log_q[2].ill, log_q[2].wr}, 2'b10);
      chk("ill_next", log_q[3].pc, 16'h0003);
      chk("juc_rs1", log_q[3].rs1, 4'd5);
      chk("juc_wr", log_q[3].wr, 0);
      chk("juc_next", log_q[4].pc, 16'h1234);
      chk("beq_pc", log_q[5].pc, 16'h0010);
      chk("beq_taken", log_q[6].pc, 16'h000C);
      chk("ori_imm", log_q[7].imm, 16'hFF80);
      chk("lui_ctl", {log_q[8].imm, log_q[8].alu, log_q[8].uimm}, {16'hAB00, 3'b101, 1'b1});
      chk("beq_nt_pc", log_q[10].pc, 16'h0010);
      chk("beq_nt", log_q[11].pc, 16'h0011);
      chk("bne_pc", log_q[12].pc, 16'hFFFF);
      chk("bne_wrap", log_q[13].pc, 16'h0000);
      chk("halt_ir", log_q[13].ir, 16'h4000);
    end

    ready_mode = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("lit_unhalt", bif.halted, 0);
    chk("lit_rst_pc2", bif.pc, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("lit_fetchwait_req", bif.instr_req, 1);
    reset = 1'b0;
    #1;
    chk("lit_abort_req", bif.instr_req, 0);
    chk("lit_abort_en", {bif.write, bif.flag_we, bif.illegal, bif.halted}, 0);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
